// File: rtl/wb32_sram16_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb32_sram16_pkg                                                    |
// | FSM states and halfword-presence decode for the 32-to-16 bridge.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package wb32_sram16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    ACK  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_LO = 2'b01;
  localparam logic [1:0] SEL_HI = 2'b10;

  // Bit 0 set when the low halfword has any byte enabled, bit 1 for the high one.
  function automatic logic [1:0] halves(input logic [3:0] sel);
    return {|sel[3:2], |sel[1:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb32_sram16_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb32_sram16_bridge                                                 |
// | Wishbone 32-bit slave split into up to two 16-bit SRAM accesses.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module wb32_sram16_bridge #(
  parameter int ADR_W = 20
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             s_cyc_i,
  input  logic             s_stb_i,
  input  logic             s_we_i,
  input  logic [3:0]       s_sel_i,
  input  logic [ADR_W-3:0] s_adr_i,
  input  logic [31:0]      s_dat_i,
  output logic [31:0]      s_dat_o,
  output logic             s_ack_o,
  output logic [ADR_W-2:0] m_adr_o,
  output logic [15:0]      m_dat_o,
  input  logic [15:0]      m_dat_i,
  output logic [1:0]       m_sel_o,
  output logic             m_we_o,
  output logic             m_stb_o,
  input  logic             m_ack_i
);
  import wb32_sram16_pkg::*;

  state_t           state, state_nxt;
  logic [ADR_W-3:0] adr_q, adr_n;
  logic             we_q, we_n;
  logic [3:0]       sel_q, sel_n;
  logic [31:0]      dat_q, dat_n;
  logic [31:0]      rd_q, rd_n;
  logic             s_ack_n;
  logic [31:0]      s_dat_n;
  logic [ADR_W-2:0] m_adr_n;
  logic [15:0]      m_dat_n;
  logic [1:0]       m_sel_n;
  logic             m_we_n;
  logic             m_stb_n;
  logic [1:0]       pres;

  always_comb begin
    state_nxt = state;
    adr_n     = adr_q;
    we_n      = we_q;
    sel_n     = sel_q;
    dat_n     = dat_q;
    rd_n      = rd_q;
    s_ack_n   = 1'b0;
    s_dat_n   = s_dat_o;
    pres      = halves(sel_q);

    case (state)
      IDLE: begin
        rd_n = 32'd0;
        if (s_cyc_i && s_stb_i && !s_ack_o) begin
          adr_n = s_adr_i;
          we_n  = s_we_i;
          sel_n = s_sel_i;
          dat_n = s_dat_i;
          pres  = halves(s_sel_i);
          if ((pres & SEL_LO) != 2'b00)      state_nxt = LO;
          else if ((pres & SEL_HI) != 2'b00) state_nxt = HI;
          else                               state_nxt = ACK;
        end
      end
      LO: begin
        if (m_ack_i) begin
          if (!we_q) rd_n[15:0] = m_dat_i;
          if (!s_cyc_i)                      state_nxt = IDLE;
          else if ((pres & SEL_HI) != 2'b00) state_nxt = HI;
          else                               state_nxt = ACK;
        end
      end
      HI: begin
        if (m_ack_i) begin
          if (!we_q) rd_n[31:16] = m_dat_i;
          state_nxt = s_cyc_i ? ACK : IDLE;
        end
      end
      ACK: begin
        s_ack_n   = 1'b1;
        s_dat_n   = rd_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Downstream outputs are a function of the state being entered, so they
  // are registered and steady for the whole SRAM cycle.
  always_comb begin
    m_stb_n = 1'b0;
    m_we_n  = 1'b0;
    m_sel_n = 2'b00;
    m_adr_n = '0;
    m_dat_n = 16'd0;
    if (state_nxt == LO) begin
      m_stb_n = 1'b1;
      m_we_n  = we_n;
      m_sel_n = sel_n[1:0];
      m_adr_n = {adr_n, 1'b0};
      m_dat_n = dat_n[15:0];
    end else if (state_nxt == HI) begin
      m_stb_n = 1'b1;
      m_we_n  = we_n;
      m_sel_n = sel_n[3:2];
      m_adr_n = {adr_n, 1'b1};
      m_dat_n = dat_n[31:16];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      dat_q   <= 32'd0;
      rd_q    <= 32'd0;
      s_ack_o <= 1'b0;
      s_dat_o <= 32'd0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_sel_o <= 2'b00;
      m_adr_o <= '0;
      m_dat_o <= 16'd0;
    end else begin
      state   <= state_nxt;
      adr_q   <= adr_n;
      we_q    <= we_n;
      sel_q   <= sel_n;
      dat_q   <= dat_n;
      rd_q    <= rd_n;
      s_ack_o <= s_ack_n;
      s_dat_o <= s_dat_n;
      m_stb_o <= m_stb_n;
      m_we_o  <= m_we_n;
      m_sel_o <= m_sel_n;
      m_adr_o <= m_adr_n;
      m_dat_o <= m_dat_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb32_sram16_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_wb32_sram16_bridge                                              |
// | Directed vector table plus corner sequences against an SRAM model. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_wb32_sram16_bridge;

  localparam int ADR_W = 20;
  localparam int NV    = 9;

  logic             clk;
  logic             rst;
  logic             s_cyc, s_stb, s_we;
  logic [3:0]       s_sel;
  logic [ADR_W-3:0] s_adr;
  logic [31:0]      s_wdat, s_rdat;
  logic             s_ack;
  logic [ADR_W-2:0] m_adr;
  logic [15:0]      m_wdat, m_rdat;
  logic [1:0]       m_sel;
  logic             m_we, m_stb, m_ack;
  logic             ack_en;

  wb32_sram16_bridge #(.ADR_W(ADR_W)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .s_cyc_i (s_cyc),
    .s_stb_i (s_stb),
    .s_we_i  (s_we),
    .s_sel_i (s_sel),
    .s_adr_i (s_adr),
    .s_dat_i (s_wdat),
    .s_dat_o (s_rdat),
    .s_ack_o (s_ack),
    .m_adr_o (m_adr),
    .m_dat_o (m_wdat),
    .m_dat_i (m_rdat),
    .m_sel_o (m_sel),
    .m_we_o  (m_we),
    .m_stb_o (m_stb),
    .m_ack_i (m_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: combinational ack gated by ack_en for wait states.
  logic [15:0] mem [0:1023];
  assign m_ack  = m_stb & ack_en;
  assign m_rdat = mem[m_adr[9:0]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'd0;
    end else if (m_stb && m_ack && m_we) begin
      if (m_sel[0]) mem[m_adr[9:0]][7:0]  <= m_wdat[7:0];
      if (m_sel[1]) mem[m_adr[9:0]][15:8] <= m_wdat[15:8];
    end
  end

  typedef struct {
    logic [ADR_W-2:0] adr;
    logic [1:0]       sel;
    logic             we;
    logic [15:0]      dat;
  } acc_t;

  acc_t log_q[$];
  int   ack_count = 0;

  always @(posedge clk) begin
    if (m_stb && m_ack) log_q.push_back('{m_adr, m_sel, m_we, m_wdat});
    if (s_ack) ack_count <= ack_count + 1;
  end

  typedef struct {
    logic             we;
    logic [3:0]       sel;
    logic [ADR_W-3:0] adr;
    logic [31:0]      wdat;
    logic [31:0]      exp_rd;
    int               exp_lat;
    int               exp_nacc;
    logic [ADR_W-2:0] exp_a0;
    logic [1:0]       exp_s0;
  } vec_t;

  vec_t vecs[NV];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_req(input logic we, input logic [3:0] sel,
                           input logic [ADR_W-3:0] adr, input logic [31:0] dat);
    @(negedge clk);
    s_cyc  = 1'b1;
    s_stb  = 1'b1;
    s_we   = we;
    s_sel  = sel;
    s_adr  = adr;
    s_wdat = dat;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (s_ack) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_txn(input string name, input logic we, input logic [3:0] sel,
                         input logic [ADR_W-3:0] adr, input logic [31:0] dat,
                         output int lat, output logic [31:0] rdat);
    start_req(we, sel, adr, dat);
    wait_ack(lat);
    rdat  = s_rdat;
    s_cyc = 1'b0;
    s_stb = 1'b0;
    @(posedge clk);
    #1;
    chk({name, "_ack_one_cycle"}, 32'(s_ack), 32'd0);
  endtask

  int          lat, base, acks0;
  logic [31:0] rdat;
  logic [22:0] snap_ctl;
  logic [15:0] snap_dat;

  initial begin
    vecs[0] = '{1'b0, 4'hF, 18'h100, 32'h0,        32'hDEADBEEF, 3, 2, 19'h200, 2'b11};
    vecs[1] = '{1'b1, 4'h8, 18'h101, 32'h12345678, 32'h0,        2, 1, 19'h203, 2'b10};
    vecs[2] = '{1'b0, 4'hF, 18'h101, 32'h0,        32'h12000000, 3, 2, 19'h202, 2'b11};
    vecs[3] = '{1'b0, 4'h3, 18'h100, 32'h0,        32'h0000BEEF, 2, 1, 19'h200, 2'b11};
    vecs[4] = '{1'b0, 4'hC, 18'h100, 32'h0,        32'hDEAD0000, 2, 1, 19'h201, 2'b11};
    vecs[5] = '{1'b0, 4'h0, 18'h100, 32'h0,        32'h0,        1, 0, 19'h0,   2'b00};
    vecs[6] = '{1'b1, 4'h5, 18'h102, 32'hAABBCCDD, 32'h0,        3, 2, 19'h204, 2'b01};
    vecs[7] = '{1'b0, 4'hF, 18'h102, 32'h0,        32'h00BB00DD, 3, 2, 19'h204, 2'b11};
    vecs[8] = '{1'b0, 4'h2, 18'h100, 32'h0,        32'h0000BEEF, 2, 1, 19'h200, 2'b10};

    rst = 1'b1; s_cyc = 1'b0; s_stb = 1'b0; s_we = 1'b0; s_sel = 4'h0;
    s_adr = '0; s_wdat = 32'h0; ack_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_s_ack",  32'(s_ack),  32'd0);
    chk("reset_s_dat",  s_rdat,      32'd0);
    chk("reset_m_stb",  32'(m_stb),  32'd0);
    chk("reset_m_ctl",  32'({m_we, m_sel, m_adr}), 32'd0);
    chk("reset_m_dat",  32'(m_wdat), 32'd0);
    rst = 1'b0;

    // Full-word write: two halfwords, low first.
    base = log_q.size();
    run_txn("wr32", 1'b1, 4'hF, 18'h100, 32'hDEADBEEF, lat, rdat);
    chk("wr32_lat",  32'(lat), 32'd3);
    chk("wr32_nacc", 32'(log_q.size() - base), 32'd2);
    if (log_q.size() - base == 2) begin
      chk("wr32_acc0", {log_q[base].we, log_q[base].sel, log_q[base].adr[11:0], log_q[base].dat},
          {1'b1, 2'b11, 12'h200, 16'hBEEF} );
      chk("wr32_acc1", {log_q[base+1].we, log_q[base+1].sel, log_q[base+1].adr[11:0], log_q[base+1].dat},
          {1'b1, 2'b11, 12'h201, 16'hDEAD});
    end

    for (int i = 0; i < NV; i++) begin
      string nm;
      nm   = $sformatf("vec%0d", i);
      base = log_q.size();
      run_txn(nm, vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].wdat, lat, rdat);
      chk({nm, "_lat"},  32'(lat), 32'(vecs[i].exp_lat));
      chk({nm, "_rdat"}, rdat, vecs[i].exp_rd);
      chk({nm, "_nacc"}, 32'(log_q.size() - base), 32'(vecs[i].exp_nacc));
      if (vecs[i].exp_nacc > 0 && log_q.size() > base)
        chk({nm, "_first_acc"}, 32'({log_q[base].adr, log_q[base].sel}),
            32'({vecs[i].exp_a0, vecs[i].exp_s0}));
      for (int k = base; k < log_q.size(); k++)
        chk({nm, "_we"}, 32'(log_q[k].we), 32'(vecs[i].we));
    end

    // Wait states in LO: outputs frozen, no ack until the SRAM answers.
    ack_en = 1'b0;
    base   = log_q.size();
    acks0  = ack_count;
    start_req(1'b1, 4'hF, 18'h110, 32'h11223344);
    snap_ctl = {m_stb, m_we, m_sel, m_adr};
    snap_dat = m_wdat;
    chk("ws_lo_drive", 32'({snap_ctl, snap_dat[7:0]}), 32'({1'b1, 1'b1, 2'b11, 19'h220, 8'h44}));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("ws_ctl_stable%0d", c), 32'({m_stb, m_we, m_sel, m_adr}), 32'(snap_ctl));
      chk($sformatf("ws_dat_stable%0d", c), 32'(m_wdat), 32'(snap_dat));
      chk($sformatf("ws_no_ack%0d", c), 32'(s_ack), 32'd0);
    end
    ack_en = 1'b1;
    wait_ack(lat);
    s_cyc = 1'b0;
    s_stb = 1'b0;
    chk("ws_lat_after_release", 32'(lat), 32'd3);
    chk("ws_nacc", 32'(log_q.size() - base), 32'd2);
    run_txn("ws_rb", 1'b0, 4'hF, 18'h110, 32'h0, lat, rdat);
    chk("ws_readback", rdat, 32'h11223344);

    // Cycle abort in LO: halfword completes, then IDLE with no ack.
    base  = log_q.size();
    acks0 = ack_count;
    start_req(1'b1, 4'hF, 18'h120, 32'h55667788);
    s_cyc = 1'b0;
    s_stb = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_m_stb", 32'(m_stb), 32'd0);
    chk("abort_m_ctl", 32'({m_we, m_sel, m_adr}), 32'd0);
    chk("abort_m_dat", 32'(m_wdat), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_ack", 32'(ack_count - acks0), 32'd0);
    chk("abort_nacc",   32'(log_q.size() - base), 32'd1);

    // Reset while in HI: access dropped, all outputs cleared, no ack.
    run_txn("pre_rst", 1'b0, 4'hF, 18'h100, 32'h0, lat, rdat);
    chk("pre_rst_rdat", rdat, 32'hDEADBEEF);
    base  = log_q.size();
    acks0 = ack_count;
    start_req(1'b1, 4'hF, 18'h130, 32'h99887766);
    @(posedge clk);
    #1;
    chk("rst_in_hi", 32'({m_stb, m_adr, m_wdat}), 32'({1'b1, 19'h261, 16'h9988}) & 32'hFFFF_FFFF);
    ack_en = 1'b0;
    rst    = 1'b1;
    s_cyc  = 1'b0;
    s_stb  = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    ack_en = 1'b1;
    chk("rst_m_stb", 32'(m_stb), 32'd0);
    chk("rst_m_ctl", 32'({m_we, m_sel, m_adr}), 32'd0);
    chk("rst_m_dat", 32'(m_wdat), 32'd0);
    chk("rst_s_dat", s_rdat, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_ack", 32'(ack_count - acks0), 32'd0);
    chk("rst_nacc",   32'(log_q.size() - base), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb32_sram16_bridge.md
Name: wb32_sram16_bridge

Overview:
- Wishbone-classic slave, 32-bit data, facing the CPU/system bus; master on the 16-bit SRAM controller port.
- Splits each 32-bit access into up to two 16-bit SRAM accesses: low halfword at the even address first, then the high halfword.
- Skips halfwords whose byte selects are all zero.
- Returns one 32-bit ack to the system bus. All downstream outputs are registered, so address, select and write enable are stable for the full SRAM clock period.

Parameters:
- ADR_W, 20, byte-address width. Upstream address is [ADR_W-1:2]; downstream address is [ADR_W-1:1].

Ports:
- clk_i  in  1  system clock; same clock as the SRAM controller.
- reset_i  in  1  synchronous, active-high reset.
- s_cyc_i  in  1  upstream bus cycle.
- s_stb_i  in  1  upstream strobe.
- s_we_i  in  1  upstream write enable.
- s_sel_i  in  4  upstream byte selects; bit 0 = bits [7:0].
- s_adr_i  in  ADR_W-2  upstream word address.
- s_dat_i  in  32  upstream write data.
- s_dat_o  out  32  upstream read data; valid while s_ack_o is high.
- s_ack_o  out  1  upstream acknowledge; one-cycle pulse.
- m_adr_o  out  ADR_W-1  SRAM halfword address.
- m_dat_o  out  16  SRAM write data.
- m_dat_i  in  16  SRAM read data.
- m_sel_o  out  2  SRAM byte-lane selects.
- m_we_o  out  1  SRAM write enable.
- m_stb_o  out  1  SRAM strobe.
- m_ack_i  in  1  SRAM acknowledge. May be combinational from m_stb_o; the SRAM controller returns ack in the same cycle as stb.

Behaviour:
- FSM states: IDLE, LO, HI, ACK. All state and outputs are registered.
- Reset (synchronous): state=IDLE; s_ack_o=0, s_dat_o=0, m_stb_o=0, m_we_o=0, m_sel_o=0, m_adr_o=0, m_dat_o=0.
- Reset mid-access: the access is abandoned at that edge and no upstream ack is issued.
- IDLE:
  - When s_cyc_i & s_stb_i & ~s_ack_o, latch adr, we, sel and dat_i.
  - Clear the read-data holding register to 0.
  - Next state: LO if sel[1:0]!=0, else HI if sel[3:2]!=0, else ACK (sel=0 gives an ack with no SRAM access).
- LO:
  - Drive m_stb_o=1, m_adr_o={adr,1'b0}, m_sel_o=sel[1:0], m_we_o=we, m_dat_o=dat[15:0].
  - On m_ack_i: if ~we, capture m_dat_i into rd[15:0].
  - Next state: IDLE if s_cyc_i is low; else HI if sel[3:2]!=0; else ACK.
- HI:
  - Drive m_stb_o=1, m_adr_o={adr,1'b1}, m_sel_o=sel[3:2], m_we_o=we, m_dat_o=dat[31:16].
  - On m_ack_i: if ~we, capture rd[31:16].
  - Next state: IDLE if s_cyc_i is low; else ACK.
- LO/HI with m_ack_i low: hold state and all m_* outputs unchanged; this is the wait-state case.
- Leaving LO/HI: m_stb_o drops to 0 on the same edge; m_sel_o and m_we_o return to 0 when entering ACK or IDLE.
- ACK:
  - s_ack_o=1 for exactly one cycle; s_dat_o=rd.
  - Read halves that were not accessed return 0.
  - Return to IDLE. s_dat_o holds its value until the next ACK.
- Cycle abort: if s_cyc_i drops in LO/HI, the current halfword completes (SRAM strobe already issued), then the FSM goes to IDLE with no ack.
- Latency, from the edge that samples the request with zero wait states:
  - 32-bit access: s_ack_o at +3 cycles.
  - Single-half access: +2 cycles.
  - sel=0: +1 cycle.
- Back-to-back: a new request is accepted in IDLE the cycle after ACK. The ~s_ack_o term prevents re-accepting during the ack cycle.
- Byte order: little-endian. The halfword at the even SRAM address holds bits [15:0].

Decomposition:
- Package wb32_sram16_pkg: state enum (IDLE, LO, HI, ACK); localparams SEL_LO=2'b01, SEL_HI=2'b10 for halfword-presence decode.
- No sub-module. Lane steering is a small mux inside the FSM.

Test Plan:
- Write 0xDEADBEEF to word 0x100 with sel=4'hF. Required: SRAM sees halfword 0x200 ← 0xBEEF (sel 2'b11), then 0x201 ← 0xDEAD. s_ack_o pulses once at +3 cycles.
- Read word 0x100 after the previous write, sel=4'hF. Required: s_dat_o=0xDEADBEEF with s_ack_o; exactly two m_stb_o cycles, both with m_we_o=0.
- Write sel=4'b1000, data 0x12xxxxxx. Required: one SRAM access only, to address 0x201 with m_sel_o=2'b10 and data 0x12xx; ack at +2 cycles.
- Read with sel=4'b0000. Required: no m_stb_o; s_ack_o at +1 cycle; s_dat_o=0.
- Hold m_ack_i low 3 cycles during LO. Required: m_* outputs stable throughout, no s_ack_o; normal completion after m_ack_i rises.
- Drop s_cyc_i during LO, and separately assert reset_i during HI. Required: no s_ack_o in either case; IDLE next cycle; all m_* outputs are 0.
